// File: rtl/argmax_rows.sv
// argmax_rows
// Row-wise argmax over the final GCN class-score matrix. One row is pulled
// per handshake from the upstream product stage (read_row is the row
// address), the winning class index and score are stored per node, and
// each result is streamed out one cycle after its row was accepted.
module argmax_rows #(
  parameter int NUM_ROW    = 6,
  parameter int NUM_COL    = 3,
  parameter int DATA_WIDTH = 16,
  parameter bit SIGNED     = 1'b0,
  parameter int ROW_WIDTH  = ((NUM_ROW + 1) > 2) ? $clog2(NUM_ROW + 1) : 1,
  parameter int IDX_WIDTH  = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             row_valid,
  input  logic [NUM_COL*DATA_WIDTH-1:0]    row_data,
  output logic                             row_ready,
  output logic [ROW_WIDTH-1:0]             read_row,
  output logic                             res_valid,
  output logic [ROW_WIDTH-1:0]             res_row,
  output logic [IDX_WIDTH-1:0]             res_idx,
  output logic [DATA_WIDTH-1:0]            res_val,
  output logic [NUM_ROW*IDX_WIDTH-1:0]     max_idx,
  output logic [NUM_ROW*DATA_WIDTH-1:0]    max_val,
  output logic                             busy,
  output logic                             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [ROW_WIDTH-1:0]  r_readRow;
  logic                  r_resValid;
  logic [ROW_WIDTH-1:0]  r_resRow;
  logic [IDX_WIDTH-1:0]  r_resIdx;
  logic [DATA_WIDTH-1:0] r_resVal;
  logic                  r_busy;
  logic                  r_done;
  logic [IDX_WIDTH-1:0]  r_maxIdx [NUM_ROW];
  logic [DATA_WIDTH-1:0] r_maxVal [NUM_ROW];

  logic [DATA_WIDTH-1:0] w_col [NUM_COL];
  logic [IDX_WIDTH-1:0]  w_bestIdx;
  logic [DATA_WIDTH-1:0] w_bestVal;
  logic                  w_run;
  logic                  w_accept;
  logic                  w_startFrame;
  logic                  w_lastRow;

  // Scores are compared either as two's complement or as unsigned values.
  function automatic logic isGreater(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
    if (SIGNED) begin
      return $signed(a) > $signed(b);
    end
    return a > b;
  endfunction

  genvar gc;
  generate
    for (gc = 0; gc < NUM_COL; gc++) begin : g_col
      assign w_col[gc] = row_data[gc*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_run        = (r_state == S_RUN);
  assign row_ready    = w_run;
  assign w_accept     = w_run && row_valid;
  // A start is only honoured outside a frame, and it wins over row_valid.
  assign w_startFrame = start && !w_run;
  assign w_lastRow    = (r_readRow == ROW_WIDTH'(NUM_ROW - 1));

  // Scan columns left to right; a strictly greater score is needed to
  // replace the current best, so equal maxima keep the lowest column.
  always_comb begin
    w_bestIdx = '0;
    w_bestVal = w_col[0];
    for (int c = 1; c < NUM_COL; c++) begin
      if (isGreater(w_col[c], w_bestVal)) begin
        w_bestIdx = IDX_WIDTH'(c);
        w_bestVal = w_col[c];
      end
    end
  end

  // Frame control: state, row counter, streamed result and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_readRow  <= '0;
      r_resValid <= 1'b0;
      r_resRow   <= '0;
      r_resIdx   <= '0;
      r_resVal   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_resValid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_readRow <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_resValid <= 1'b1;
            r_resRow   <= r_readRow;
            r_resIdx   <= w_bestIdx;
            r_resVal   <= w_bestVal;
            r_readRow  <= r_readRow + ROW_WIDTH'(1);
            if (w_lastRow) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Per-row result storage: cleared by a new frame, written on each accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        r_maxIdx[r] <= '0;
        r_maxVal[r] <= '0;
      end
    end else if (w_startFrame) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        r_maxIdx[r] <= '0;
        r_maxVal[r] <= '0;
      end
    end else if (w_accept) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        if (r_readRow == ROW_WIDTH'(r)) begin
          r_maxIdx[r] <= w_bestIdx;
          r_maxVal[r] <= w_bestVal;
        end
      end
    end
  end

  genvar gr;
  generate
    for (gr = 0; gr < NUM_ROW; gr++) begin : g_pack
      assign max_idx[gr*IDX_WIDTH +: IDX_WIDTH]   = r_maxIdx[gr];
      assign max_val[gr*DATA_WIDTH +: DATA_WIDTH] = r_maxVal[gr];
    end
  endgenerate

  assign read_row  = r_readRow;
  assign res_valid = r_resValid;
  assign res_row   = r_resRow;
  assign res_idx   = r_resIdx;
  assign res_val   = r_resVal;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
